eye_width_sweep_engine: RTL
===========================

Name: eye_width_sweep_engine

Overview:
- Responder to the MBTRAIN center-calibration controller's eye-width-sweep enable.
- On enable, steps the PI phase code across its full range and runs one point test per code through the point-test handshake.
- Finds the widest contiguous all-lane-pass window, parks the PI at that window's centre, and returns a held completion ack to the controller.

Parameters:
- NUM_STEPS, 16, number of PI codes swept (0..NUM_STEPS-1); must be at most 2^PI_W.
- PI_W, 4, width of the PI step control word.
- LANES, 16, number of data lanes in a point-test result.
- SETTLE_CYCLES, 4, idle cycles after each PI code change before the point test starts (minimum 1).
- TIMEOUT_CYCLES, 1024, point-test watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active low
- i_en  in  1  sweep enable from center-cal controller; level, held high for the whole sweep
- i_mainband_or_valtrain_test  in  1  0 = mainband (all LANES evaluated), 1 = valtrain (result bit 0 only); sampled on IDLE exit
- i_pt_done  in  1  point-test completion, single-cycle pulse
- i_pt_lanes_result  in  LANES  per-lane pass (1) / fail (0); valid with i_pt_done
- o_pt_en  out  1  point-test request
- o_pt_mainband_or_valtrain  out  1  latched test type forwarded to point test
- o_pi_step  out  PI_W  analog PI control word
- o_test_ack  out  1  sweep complete; held until i_en falls
- o_center_step  out  PI_W  centre code of best window
- o_best_width  out  PI_W+1  width of best window, in codes
- o_sweep_fail  out  1  no code passed
- o_timeout  out  1  sticky watchdog flag

Behaviour:
- Asynchronous reset, active low: all outputs and internal registers go to 0; state = IDLE.
- States: IDLE, SETTLE, RUN_PT, EVAL, DONE.
- IDLE
  - On i_en=1: latch test type; code=0; clear all window trackers and o_timeout; o_pi_step=0; go to SETTLE.
- SETTLE
  - Counts SETTLE_CYCLES cycles with o_pi_step = code, then goes to RUN_PT.
- RUN_PT
  - o_pt_en=1, held continuously.
  - Result is captured on the cycle i_pt_done=1; o_pt_en=0 on the next cycle; go to EVAL.
  - An i_pt_done pulse outside RUN_PT is ignored.
- EVAL (single cycle)
  - pass = all LANES bits = 1 (mainband), or bit 0 = 1 (valtrain).
  - On pass:
    - If cur_len=0, cur_start=code.
    - cur_len++.
    - If the new cur_len > best_len (strictly greater), best_start=cur_start and best_len=cur_len. Ties keep the earliest window.
  - On fail: cur_len=0.
  - If code = NUM_STEPS-1, go to DONE. Otherwise code++ and go to SETTLE.
  - No wrap-around: windows never join code NUM_STEPS-1 to code 0.
- DONE
  - o_center_step = best_start + ((best_len-1)>>1), i.e. the lower centre for even widths.
  - o_best_width = best_len; o_pi_step = o_center_step; o_test_ack=1.
  - If best_len=0: o_sweep_fail=1, o_center_step=0, o_pi_step=0.
  - All these outputs hold until i_en=0; then go to IDLE. o_test_ack drops the same cycle i_en drops. Results stay registered until the next sweep starts.
- i_en falling in any non-IDLE state aborts the sweep:
  - Next cycle: state = IDLE, o_pt_en=0, o_test_ack=0.
  - o_pi_step keeps its last value; trackers are cleared on the next start.
- i_en re-asserted in the same cycle as abort recovery takes effect only after one IDLE cycle.
- Sweep latency (no abort, point test answering in D cycles): NUM_STEPS*(SETTLE_CYCLES+D+1) + 1 cycles from i_en to o_test_ack.

Optional Feature:
- Macro: EYE_SWEEP_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in RUN_PT.
  - If TIMEOUT_CYCLES elapse without i_pt_done: drop o_pt_en, treat the result as all-fail, set o_timeout=1 (sticky until the next sweep start), go to EVAL.
  - The counter resets on every RUN_PT entry.
- Without the macro: RUN_PT waits indefinitely and o_timeout is tied to 0.

Test Plan:
1. Mainband, point test passes all lanes (16'hFFFF) only for codes 5..10 -> o_best_width=6, o_center_step=7, o_pi_step=7, o_sweep_fail=0, o_test_ack=1 held.
2. Two windows: 2..4 and 9..11, both width 3 -> earliest kept: o_center_step=3, o_best_width=3.
3. Valtrain; bit 0 = 1 only for codes 0..3, other bits always 0 -> o_best_width=4, o_center_step=1. Same stimulus in mainband -> o_sweep_fail=1, o_center_step=0.
4. Lane 15 fails at every code while others pass (16'h7FFF) in mainband -> o_sweep_fail=1, o_best_width=0, ack still asserted after 16 points.
5. i_en dropped during RUN_PT at code 6 -> next cycle IDLE, o_pt_en=0, o_test_ack=0. Re-enable -> sweep restarts at code 0 with clean trackers.
6. EYE_SWEEP_TIMEOUT_EN, TIMEOUT_CYCLES=8, i_pt_done never returned at code 3 (all other codes pass) -> o_timeout=1. Windows 0..2 and 4..15 -> o_best_width=12, o_center_step=9.

Source files
------------

// File: rtl/eye_width_sweep_engine.sv
// Eye-width sweep engine: steps the PI code, runs one point test per code and parks the PI at the widest all-pass window.
// Optional point-test watchdog enabled by defining EYE_SWEEP_TIMEOUT_EN.
module eye_width_sweep_engine #(
  parameter int NUM_STEPS      = 16,
  parameter int PI_W           = 4,
  parameter int LANES          = 16,
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_mainband_or_valtrain_test,
  input  logic             i_pt_done,
  input  logic [LANES-1:0] i_pt_lanes_result,
  output logic             o_pt_en,
  output logic             o_pt_mainband_or_valtrain,
  output logic [PI_W-1:0]  o_pi_step,
  output logic             o_test_ack,
  output logic [PI_W-1:0]  o_center_step,
  output logic [PI_W:0]    o_best_width,
  output logic             o_sweep_fail,
  output logic             o_timeout
);

  typedef enum logic [2:0] {IDLE, SETTLE, RUN_PT, EVAL, DONE} state_t;

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [PI_W-1:0] LAST_CODE   = PI_W'(NUM_STEPS - 1);
  localparam logic [PI_W:0]   LEN_ONE     = (PI_W+1)'(1);

  state_t            state_r, state_s;
  logic [PI_W-1:0]   code_r, code_s;
  logic [SW-1:0]     settle_cnt_r, settle_cnt_s;
  logic              pt_en_r, pt_en_s;
  logic              test_type_r, test_type_s;
  logic              pass_r, pass_s;
  logic [PI_W-1:0]   pi_step_r, pi_step_s;
  logic [PI_W-1:0]   cur_start_r, cur_start_s;
  logic [PI_W:0]     cur_len_r, cur_len_s;
  logic [PI_W-1:0]   best_start_r, best_start_s;
  logic [PI_W:0]     best_len_r, best_len_s;
  logic              test_ack_r, test_ack_s;
  logic [PI_W-1:0]   center_r, center_s;
  logic [PI_W:0]     best_width_r, best_width_s;
  logic              sweep_fail_r, sweep_fail_s;
  logic              pass_now_s;

`ifdef EYE_SWEEP_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0]     to_cnt_r, to_cnt_s;
  logic              timeout_r, timeout_s;
`endif

  assign pass_now_s = test_type_r ? i_pt_lanes_result[0] : (&i_pt_lanes_result);

  // Next-state and next-register computation for the sweep FSM
  always_comb begin
    state_s      = state_r;
    code_s       = code_r;
    settle_cnt_s = settle_cnt_r;
    pt_en_s      = pt_en_r;
    test_type_s  = test_type_r;
    pass_s       = pass_r;
    pi_step_s    = pi_step_r;
    cur_start_s  = cur_start_r;
    cur_len_s    = cur_len_r;
    best_start_s = best_start_r;
    best_len_s   = best_len_r;
    test_ack_s   = test_ack_r;
    center_s     = center_r;
    best_width_s = best_width_r;
    sweep_fail_s = sweep_fail_r;
`ifdef EYE_SWEEP_TIMEOUT_EN
    to_cnt_s     = to_cnt_r;
    timeout_s    = timeout_r;
`endif
    // Losing enable anywhere outside IDLE abandons the sweep; the PI code is left where it was
    if (state_r != IDLE && !i_en) begin
      state_s    = IDLE;
      pt_en_s    = 1'b0;
      test_ack_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_en) begin
            test_type_s  = i_mainband_or_valtrain_test;
            code_s       = '0;
            settle_cnt_s = '0;
            pi_step_s    = '0;
            cur_start_s  = '0;
            cur_len_s    = '0;
            best_start_s = '0;
            best_len_s   = '0;
            test_ack_s   = 1'b0;
            center_s     = '0;
            best_width_s = '0;
            sweep_fail_s = 1'b0;
`ifdef EYE_SWEEP_TIMEOUT_EN
            timeout_s    = 1'b0;
`endif
            state_s      = SETTLE;
          end else begin
            state_s = IDLE;
          end
        end
        SETTLE: begin
          if (settle_cnt_r == SETTLE_LAST) begin
            pt_en_s = 1'b1;
`ifdef EYE_SWEEP_TIMEOUT_EN
            to_cnt_s = '0;
`endif
            state_s = RUN_PT;
          end else begin
            settle_cnt_s = settle_cnt_r + SW'(1);
          end
        end
        RUN_PT: begin
          if (i_pt_done) begin
            pass_s  = pass_now_s;
            pt_en_s = 1'b0;
            state_s = EVAL;
          end
`ifdef EYE_SWEEP_TIMEOUT_EN
          else if (to_cnt_r == TO_LAST) begin
            pass_s    = 1'b0;
            pt_en_s   = 1'b0;
            timeout_s = 1'b1;
            state_s   = EVAL;
          end else begin
            to_cnt_s = to_cnt_r + TW'(1);
          end
`else
          else begin
            pt_en_s = 1'b1;
          end
`endif
        end
        EVAL: begin
          if (pass_r) begin
            if (cur_len_r == '0) begin
              cur_start_s = code_r;
            end else begin
              cur_start_s = cur_start_r;
            end
            cur_len_s = cur_len_r + LEN_ONE;
            // Strictly greater keeps the earliest of equal-width windows
            if (cur_len_s > best_len_r) begin
              best_start_s = cur_start_s;
              best_len_s   = cur_len_s;
            end else begin
              best_start_s = best_start_r;
            end
          end else begin
            cur_len_s = '0;
          end
          if (code_r == LAST_CODE) begin
            state_s      = DONE;
            test_ack_s   = 1'b1;
            best_width_s = best_len_s;
            if (best_len_s == '0) begin
              sweep_fail_s = 1'b1;
              center_s     = '0;
              pi_step_s    = '0;
            end else begin
              sweep_fail_s = 1'b0;
              center_s     = best_start_s + PI_W'((best_len_s - LEN_ONE) >> 1);
              pi_step_s    = center_s;
            end
          end else begin
            code_s       = code_r + PI_W'(1);
            pi_step_s    = code_r + PI_W'(1);
            settle_cnt_s = '0;
            state_s      = SETTLE;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      code_r       <= '0;
      settle_cnt_r <= '0;
      pt_en_r      <= 1'b0;
      test_type_r  <= 1'b0;
      pass_r       <= 1'b0;
      pi_step_r    <= '0;
      cur_start_r  <= '0;
      cur_len_r    <= '0;
      best_start_r <= '0;
      best_len_r   <= '0;
      test_ack_r   <= 1'b0;
      center_r     <= '0;
      best_width_r <= '0;
      sweep_fail_r <= 1'b0;
`ifdef EYE_SWEEP_TIMEOUT_EN
      to_cnt_r     <= '0;
      timeout_r    <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      code_r       <= code_s;
      settle_cnt_r <= settle_cnt_s;
      pt_en_r      <= pt_en_s;
      test_type_r  <= test_type_s;
      pass_r       <= pass_s;
      pi_step_r    <= pi_step_s;
      cur_start_r  <= cur_start_s;
      cur_len_r    <= cur_len_s;
      best_start_r <= best_start_s;
      best_len_r   <= best_len_s;
      test_ack_r   <= test_ack_s;
      center_r     <= center_s;
      best_width_r <= best_width_s;
      sweep_fail_r <= sweep_fail_s;
`ifdef EYE_SWEEP_TIMEOUT_EN
      to_cnt_r     <= to_cnt_s;
      timeout_r    <= timeout_s;
`endif
    end
  end

  assign o_pt_en                   = pt_en_r;
  assign o_pt_mainband_or_valtrain = test_type_r;
  assign o_pi_step                 = pi_step_r;
  // Ack falls in the same cycle the controller withdraws enable
  assign o_test_ack                = test_ack_r & i_en;
  assign o_center_step             = center_r;
  assign o_best_width              = best_width_r;
  assign o_sweep_fail              = sweep_fail_r;
`ifdef EYE_SWEEP_TIMEOUT_EN
  assign o_timeout                 = timeout_r;
`else
  assign o_timeout                 = 1'b0;
`endif

endmodule
